core_io_responder: RTL
======================

CORE_IO_RESPONDER -- requirements
Module: core_io_responder

Interface
REQ-001 Parameter CORE, default 0, core index carried for identification only.
REQ-002 Parameter FIFO_ADDR_BITS, default 3, capture FIFO depth = 2**FIFO_ADDR_BITS entries.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 to_peripheral  input  2  tag of the core's outgoing report word.
REQ-006 to_peripheral_data  input  32  core's outgoing report word.
REQ-007 to_peripheral_valid  input  1  one-cycle qualifier for the core report word.
REQ-008 from_peripheral  output  2  tag of the core-bound word.
REQ-009 from_peripheral_data  output  32  core-bound word.
REQ-010 from_peripheral_valid  output  1  one-cycle qualifier for the core-bound word.
REQ-011 host_out_tag  output  2  tag at the FIFO head.
REQ-012 host_out_data  output  32  data at the FIFO head.
REQ-013 host_out_valid  output  1  FIFO non-empty.
REQ-014 host_out_ready  input  1  host accepts the head entry.
REQ-015 host_in_tag  input  2  tag of the host-to-core word.
REQ-016 host_in_data  input  32  host-to-core word.
REQ-017 host_in_valid  input  1  host offers a word.
REQ-018 host_in_ready  output  1  block accepts a host word.
REQ-019 drop_count  output  16  saturating count of core reports lost to a full FIFO.
REQ-020 capture_count  output  32  wrapping count of core reports accepted into the FIFO.

Function
REQ-021 Core-to-host path: a cycle with to_peripheral_valid=1 and a push permitted SHALL write {to_peripheral, to_peripheral_data} into the FIFO tail.
REQ-022 A push SHALL be permitted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-023 A pop SHALL occur when host_out_valid=1 and host_out_ready=1; host_out_tag/host_out_data SHALL present the head entry (first-word-fall-through).
REQ-024 Latency: a report pushed into an empty FIFO at edge N SHALL appear with host_out_valid=1 after edge N (registered, one cycle).
REQ-025 Simultaneous push and pop on an empty FIFO SHALL NOT pop (host_out_valid=0); the pushed entry appears next cycle.
REQ-026 Simultaneous push and pop on a non-empty FIFO SHALL leave occupancy unchanged and preserve order.
REQ-027 Read/write pointers SHALL be FIFO_ADDR_BITS+1 wide and wrap modulo 2**(FIFO_ADDR_BITS+1); full = MSBs differ with equal low bits, empty = pointers equal.
REQ-028 A rejected report (to_peripheral_valid=1, push not permitted) SHALL increment drop_count, saturating at 16'hFFFF; FIFO contents are unchanged.
REQ-029 Each accepted push SHALL increment capture_count by 1, wrapping from 32'hFFFFFFFF to 0.
REQ-030 Host-to-core path FSM states: IDLE, SEND, GAP.
REQ-031 IDLE: host_in_ready=1; on host_in_valid=1 latch tag/data into from_peripheral/from_peripheral_data, go to SEND.
REQ-032 SEND: from_peripheral_valid=1 for exactly this cycle, host_in_ready=0, go to GAP.
REQ-033 GAP: host_in_ready=0, from_peripheral_valid=0, go to IDLE; guarantees at least one idle cycle between core-bound pulses.
REQ-034 from_peripheral and from_peripheral_data SHALL hold their last value outside SEND.
REQ-035 The two paths SHALL be independent; activity on one never stalls the other.

Reset
REQ-036 While reset=1 at a posedge: FIFO emptied, pointers 0, FSM to IDLE, drop_count=0, capture_count=0, from_peripheral=0, from_peripheral_data=0, from_peripheral_valid=0.
REQ-037 In the cycle following reset: host_out_valid=0, host_in_ready=1, host_out_tag/host_out_data don't-care.
REQ-038 Reset asserted mid-operation SHALL discard all FIFO entries, suppress any pending SEND pulse, and ignore to_peripheral_valid and host_in_valid in that cycle.

Verification
REQ-039 Single report: to_peripheral=0, data=32'd55, valid 1 cycle, host_out_ready=0 -> next cycle host_out_valid=1, host_out_data=55, capture_count=1; stays until ready.
REQ-040 Overflow (FIFO_ADDR_BITS=3): 10 back-to-back reports 1..10, host_out_ready=0 -> 8 held, drop_count=2, capture_count=8; draining yields 1..8 in order, then host_out_valid=0.
REQ-041 Full + simultaneous pop: FIFO full with 1..8, host_out_ready=1 and report 9 in same cycle -> 1 popped, 9 accepted, drop_count unchanged, drain order 2..9.
REQ-042 Host-to-core: host_in_valid held 1 with data 32'hA5A5_0001 then 32'hA5A5_0002, tag 2 -> from_peripheral_valid pulses exactly one cycle each, pulses separated by 2 cycles, tag 2, data in order.
REQ-043 Wrap-around: 20 push/pop cycles at ready=1 with depth 8 -> every value delivered once, in order, no drops.
REQ-044 Reset mid-operation: 5 entries queued and FSM in SEND, reset 1 cycle -> next cycle host_out_valid=0, from_peripheral_valid=0, counters 0, host_in_ready=1.

Source files
------------

// File: rtl/core_io_responder.sv
// rtl/core_io_responder.sv - core report capture FIFO and host-to-core pulse sender
//
// Core reports go into a first-word-fall-through queue that the host drains.
// Host words go out to the core as single-cycle pulses, spaced by at least
// one idle cycle.

module core_io_capture_fifo #(
  parameter int ADDR_BITS = 3,
  parameter int WIDTH     = 34
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;

  // The extra pointer bit tells a full queue from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                 (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
  assign rdata = mem[rd_ptr[ADDR_BITS-1:0]];

  // Pointer update; reset discards every queued entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; on full-with-pop the tail slot is the slot being freed.
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr[ADDR_BITS-1:0]] <= wdata;
  end

endmodule

module core_io_responder #(
  parameter int CORE           = 0,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  to_peripheral,
  input  logic [31:0] to_peripheral_data,
  input  logic        to_peripheral_valid,
  output logic [1:0]  from_peripheral,
  output logic [31:0] from_peripheral_data,
  output logic        from_peripheral_valid,
  output logic [1:0]  host_out_tag,
  output logic [31:0] host_out_data,
  output logic        host_out_valid,
  input  logic        host_out_ready,
  input  logic [1:0]  host_in_tag,
  input  logic [31:0] host_in_data,
  input  logic        host_in_valid,
  output logic        host_in_ready,
  output logic [15:0] drop_count,
  output logic [31:0] capture_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } send_state_t;

  send_state_t state;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_pop;
  logic        do_push;
  logic [33:0] head;

  // A pop frees a slot in the same cycle, so a full queue still takes a report.
  assign do_pop         = !fifo_empty && host_out_ready;
  assign do_push        = to_peripheral_valid && (!fifo_full || do_pop);
  assign host_out_valid = !fifo_empty;
  assign host_out_tag   = head[33:32];
  assign host_out_data  = head[31:0];

  core_io_capture_fifo #(
    .ADDR_BITS (FIFO_ADDR_BITS),
    .WIDTH     (34)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .wdata ({to_peripheral, to_peripheral_data}),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Accepted reports wrap; lost reports saturate so a long overflow stays visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count    <= '0;
      capture_count <= '0;
    end else begin
      if (do_push) begin
        capture_count <= capture_count + 32'd1;
      end else if (to_peripheral_valid && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Host-to-core sender: latch a word, pulse it for one cycle, then rest one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= ST_IDLE;
      host_in_ready         <= 1'b1;
      from_peripheral       <= '0;
      from_peripheral_data  <= '0;
      from_peripheral_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host_in_valid) begin
            from_peripheral       <= host_in_tag;
            from_peripheral_data  <= host_in_data;
            from_peripheral_valid <= 1'b1;
            host_in_ready         <= 1'b0;
            state                 <= ST_SEND;
          end
        end
        ST_SEND: begin
          from_peripheral_valid <= 1'b0;
          state                 <= ST_GAP;
        end
        ST_GAP: begin
          host_in_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          from_peripheral_valid <= 1'b0;
          host_in_ready         <= 1'b1;
          state                 <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
